// File: rtl/fir_alu_sequencer_pkg.sv
// Shared constants, ALU opcodes and sequencer state type for the FIR ALU sequencer.
// Used by fir_alu_sequencer and fir_delay_line.
package fir_pkg;

  localparam int TAPS_DEF    = 64;
  localparam int DW_DEF      = 16;
  localparam int ALU_LAT_DEF = 2;
  localparam int OUT_W_DEF   = 32;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_MUL = 2'b01;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

endpackage

// File: rtl/fir_alu_sequencer_delay_line.sv
// Circular sample buffer: one write per accepted sample, read at an offset behind the newest entry.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DW-1:0]           wdata,
  input  logic [$clog2(TAPS)-1:0] rd_ofs,
  output logic [DW-1:0]           rd_data
);

  localparam int AW = $clog2(TAPS);

  logic [TAPS-1:0][DW-1:0] mem;
  logic [AW-1:0]           wptr;
  logic [AW-1:0]           rd_idx;

  // wptr already points past the newest sample, so offset 0 reads wptr-1.
  assign rd_idx  = wptr - AW'(1) - rd_ofs;
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem  <= '0;
      wptr <= '0;
    end else if (we) begin
      mem[wptr] <= wdata;
      wptr      <= wptr + AW'(1);
    end
  end

endmodule

// File: rtl/fir_alu_sequencer.sv
// FIR sequencer: issues TAPS multiplies to an external ALU per sample and accumulates the products.
// Define FIR_SAT_EN to saturate out_data to the signed OUT_W range instead of wrapping.
module fir_alu_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS    = TAPS_DEF,
  parameter int DW      = DW_DEF,
  parameter int ALU_LAT = ALU_LAT_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_sample,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [DW-1:0]           coef_data,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  output logic [1:0]              alu_op_sel,
  input  logic [31:0]             alu_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data
);

  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = 2*DW + AW;

  state_t                  state, state_nxt;
  logic [AW-1:0]           cnt;
  logic [TAPS-1:0][DW-1:0] coef;
  logic [ALU_LAT-1:0]      vld_pipe;
  logic signed [ACC_W-1:0] acc;
  logic [DW-1:0]           dl_rd;
  logic                    accept;
  logic                    issue;
  logic [OUT_W-1:0]        out_val;

  assign accept = (state == IDLE) && in_valid;

  fir_delay_line #(.TAPS(TAPS), .DW(DW)) u_dl (
    .clk     (clk),
    .rst     (rst),
    .we      (accept),
    .wdata   (in_sample),
    .rd_ofs  (cnt),
    .rd_data (dl_rd)
  );

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);

  assign out_val = (acc > SAT_HI) ? {1'b0, {(OUT_W-1){1'b1}}} :
                   (acc < SAT_LO) ? {1'b1, {(OUT_W-1){1'b0}}} :
                   acc[OUT_W-1:0];
`else
  assign out_val = acc[OUT_W-1:0];
`endif

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op_sel = ALU_OP_ADD;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        alu_a      = dl_rd;
        alu_b      = coef[cnt];
        alu_op_sel = ALU_OP_MUL;
        issue      = 1'b1;
        if (cnt == AW'(TAPS-1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cnt == AW'(ALU_LAT-1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = out_val;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      coef     <= '0;
      vld_pipe <= '0;
      acc      <= '0;
    end else begin
      state    <= state_nxt;
      // cnt restarts on every state change; it times ISSUE taps and DRAIN cycles
      cnt      <= (state_nxt != state) ? '0 : cnt + AW'(1);
      vld_pipe <= (vld_pipe << 1) | ALU_LAT'(issue);
      if (state == IDLE && coef_we) coef[coef_addr] <= coef_data;
      if (accept)
        acc <= '0;
      else if (vld_pipe[ALU_LAT-1])
        acc <= acc + {{(ACC_W-32){alu_result[31]}}, alu_result};
    end
  end

endmodule
